mux_n_sync: RTL

MUX_N_SYNC -- requirements
Module: mux_n_sync

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_guard_cnt.sv | 35 +++
 rtl/mux_n_sync.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared state encoding, default timing values and counter sizing helper for mux_n_sync.
package mux_pkg;

    typedef enum logic {
        StActive = 1'b0,
        StBlank  = 1'b1
    } mux_state_e;

    localparam int unsigned DEF_GUARD = 4;
    localparam int unsigned DEF_DWELL = 16;

    // Bits needed to hold n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/mux_guard_cnt.sv
// Loadable saturating down-counter with zero flag; used for both guard and dwell timing.
module mux_guard_cnt #(
    parameter int unsigned     CW      = 2,
    parameter logic [CW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_n_sync.sv
// Registered N-channel mux with guard blanking after each switch.
// Optional auto-scan of channels is enabled by defining MUX_N_SYNC_SCAN_EN.
module mux_n_sync
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned SELW  = 3,
    parameter int unsigned GUARD = DEF_GUARD,
    parameter int unsigned DWELL = DEF_DWELL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   x,
    input  logic [SELW-1:0]     sel_req,
    input  logic                sel_load,
    input  logic                scan_en,
    output logic [W-1:0]        y,
    output logic                y_valid,
    output logic [SELW-1:0]     cur_sel,
    output logic                sel_busy,
    output logic                sel_err
);

    localparam int unsigned    GCW        = cnt_width(GUARD);
    localparam logic [GCW-1:0] GUARD_INIT = GCW'(GUARD - 1);

    mux_state_e    state_q, state_d;
    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic [W-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic          sel_busy_q, sel_busy_d;
    logic          sel_err_q, sel_err_d;

    logic          sel_ok, req_switch, scan_adv, guard_zero;
    logic [SELW-1:0] scan_sel;

    // Unused select codes read as zero so the index is always in range.
    logic [W-1:0]  ch [2**SELW];
    for (genvar i = 0; i < 2**SELW; i++) begin : g_ch
        if (i < N_CH) begin : g_used
            assign ch[i] = x[i*W +: W];
        end else begin : g_pad
            assign ch[i] = '0;
        end
    end

    assign sel_ok     = (32'(sel_req) < N_CH);
    assign req_switch = sel_load && sel_ok && (state_q == StActive) && (sel_req != cur_sel_q);

`ifdef MUX_N_SYNC_SCAN_EN
    localparam int unsigned     DCW     = cnt_width(DWELL);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

    logic dwell_zero, dwell_run;

    // Counts only while scanning in ACTIVE; otherwise held reloaded to DWELL-1.
    assign dwell_run = (state_q == StActive) && scan_en && !req_switch && !dwell_zero;
    assign scan_adv  = (state_q == StActive) && scan_en && dwell_zero && !req_switch;
    assign scan_sel  = (cur_sel_q == LAST_CH) ? '0 : cur_sel_q + SELW'(1);

    mux_guard_cnt #(
        .CW      (DCW),
        .RST_VAL ('0)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (!dwell_run),
        .load_val (DCW'(DWELL - 1)),
        .dec      (dwell_run),
        .zero     (dwell_zero)
    );
`else
    localparam int unsigned unused_dwell = DWELL;
    logic unused_scan_en;

    assign unused_scan_en = scan_en;
    assign scan_adv       = 1'b0;
    assign scan_sel       = cur_sel_q;
`endif

    mux_guard_cnt #(
        .CW      (GCW),
        .RST_VAL (GUARD_INIT)
    ) u_guard_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (req_switch || scan_adv),
        .load_val (GUARD_INIT),
        .dec      (state_q == StBlank),
        .zero     (guard_zero)
    );

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        sel_busy_d = sel_busy_q;
        sel_err_d  = sel_load && !sel_ok;

        unique case (state_q)
            StActive: begin
                if (req_switch || scan_adv) begin
                    cur_sel_d  = req_switch ? sel_req : scan_sel;
                    state_d    = StBlank;
                    y_d        = '0;
                    y_valid_d  = 1'b0;
                    sel_busy_d = 1'b1;
                end else begin
                    y_d        = ch[cur_sel_q];
                    y_valid_d  = 1'b1;
                    sel_busy_d = 1'b0;
                end
            end
            StBlank: begin
                if (guard_zero) begin
                    state_d    = StActive;
                    y_d        = ch[cur_sel_q];
                    y_valid_d  = 1'b1;
                    sel_busy_d = 1'b0;
                end else begin
                    y_d        = '0;
                    y_valid_d  = 1'b0;
                    sel_busy_d = 1'b1;
                end
            end
            default: state_d = StBlank;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBlank;
            cur_sel_q  <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            sel_busy_q <= 1'b1;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            sel_busy_q <= sel_busy_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign cur_sel  = cur_sel_q;
    assign sel_busy = sel_busy_q;
    assign sel_err  = sel_err_q;

endmodule
